// File: rtl/wb_pkg.sv
// Shared types and widths for the Wishbone classic initiator.
// Bus widths, FSM state encoding and the data word returned on an aborted transfer.
package wb_pkg;

    localparam int WB_AW   = 32;
    localparam int WB_DW   = 32;
    localparam int WB_SELW = 4;

    localparam logic [WB_DW-1:0] RSP_ERR_DATA = 32'h0;

    typedef enum logic [1:0] {
        IDLE,
        BUS,
        RESP
    } wb_init_state_e;

endpackage

// File: rtl/wb_timeout_ctr.sv
// Ack-wait counter: expired is high in the cycle where TIMEOUT-1 stb cycles have already elapsed.
// Saturates at all-ones instead of wrapping; TIMEOUT=0 disables expiry entirely.
module wb_timeout_ctr #(
    parameter int TIMEOUT = 255,
    parameter int TO_W    = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic expired
);

    logic [TO_W-1:0] cnt_q;
    logic [TO_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en && (cnt_q != {TO_W{1'b1}})) begin
            cnt_d = cnt_q + TO_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired = (TIMEOUT != 0) && (cnt_q == TO_W'(TIMEOUT - 1));

endmodule

// File: rtl/wb_classic_initiator.sv
// Wishbone classic single-transfer master: one valid/ready command in, one WB cycle, one response out.
// All outputs registered; accept-to-stb latency 1 cycle; response held until rsp_ready, 3-clock minimum turnaround.
module wb_classic_initiator
    import wb_pkg::*;
#(
    parameter int TIMEOUT = 255,
    parameter int TO_W    = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               req_valid,
    output logic               req_ready,
    input  logic               req_we,
    input  logic [WB_AW-1:0]   req_adr,
    input  logic [WB_DW-1:0]   req_dat,
    input  logic [WB_SELW-1:0] req_sel,
    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic [WB_DW-1:0]   rsp_dat,
    output logic               rsp_err,
    output logic               wbm_cyc_o,
    output logic               wbm_stb_o,
    output logic               wbm_we_o,
    output logic [WB_SELW-1:0] wbm_sel_o,
    output logic [WB_AW-1:0]   wbm_adr_o,
    output logic [WB_DW-1:0]   wbm_dat_o,
    input  logic [WB_DW-1:0]   wbm_dat_i,
    input  logic               wbm_ack_i,
    output logic               busy
);

    wb_init_state_e     state_q, state_d;
    logic               req_ready_q, req_ready_d;
    logic               cyc_q, cyc_d;
    logic               we_q, we_d;
    logic [WB_SELW-1:0] sel_q, sel_d;
    logic [WB_AW-1:0]   adr_q, adr_d;
    logic [WB_DW-1:0]   dat_q, dat_d;
    logic               rsp_valid_q, rsp_valid_d;
    logic [WB_DW-1:0]   rsp_dat_q, rsp_dat_d;
    logic               rsp_err_q, rsp_err_d;
    logic               ctr_clr;
    logic               ctr_en;
    logic               expired;

    wb_timeout_ctr #(
        .TIMEOUT (TIMEOUT),
        .TO_W    (TO_W)
    ) u_timeout (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr     (ctr_clr),
        .en      (ctr_en),
        .expired (expired)
    );

    always_comb begin
        state_d     = state_q;
        req_ready_d = req_ready_q;
        cyc_d       = cyc_q;
        we_d        = we_q;
        sel_d       = sel_q;
        adr_d       = adr_q;
        dat_d       = dat_q;
        rsp_valid_d = rsp_valid_q;
        rsp_dat_d   = rsp_dat_q;
        rsp_err_d   = rsp_err_q;
        ctr_clr     = 1'b0;
        ctr_en      = 1'b0;
        case (state_q)
            IDLE: begin
                if (req_valid && req_ready_q) begin
                    state_d     = BUS;
                    req_ready_d = 1'b0;
                    cyc_d       = 1'b1;
                    we_d        = req_we;
                    sel_d       = req_sel;
                    adr_d       = req_adr;
                    dat_d       = req_we ? req_dat : '0;
                    ctr_clr     = 1'b1;
                end else begin
                    req_ready_d = 1'b1;
                end
            end
            BUS: begin
                ctr_en = 1'b1;
                // Ack is checked first so a same-cycle ack beats the timeout.
                if (wbm_ack_i || expired) begin
                    state_d     = RESP;
                    cyc_d       = 1'b0;
                    we_d        = 1'b0;
                    sel_d       = '0;
                    adr_d       = '0;
                    dat_d       = '0;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = !wbm_ack_i;
                    if (!wbm_ack_i) begin
                        rsp_dat_d = RSP_ERR_DATA;
                    end else begin
                        rsp_dat_d = we_q ? '0 : wbm_dat_i;
                    end
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_d     = IDLE;
                    rsp_valid_d = 1'b0;
                    req_ready_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            req_ready_q <= 1'b0;
            cyc_q       <= 1'b0;
            we_q        <= 1'b0;
            sel_q       <= '0;
            adr_q       <= '0;
            dat_q       <= '0;
            rsp_valid_q <= 1'b0;
            rsp_dat_q   <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            req_ready_q <= req_ready_d;
            cyc_q       <= cyc_d;
            we_q        <= we_d;
            sel_q       <= sel_d;
            adr_q       <= adr_d;
            dat_q       <= dat_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_dat_q   <= rsp_dat_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    assign req_ready = req_ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_dat   = rsp_dat_q;
    assign rsp_err   = rsp_err_q;
    assign wbm_cyc_o = cyc_q;
    assign wbm_stb_o = cyc_q;
    assign wbm_we_o  = we_q;
    assign wbm_sel_o = sel_q;
    assign wbm_adr_o = adr_q;
    assign wbm_dat_o = dat_q;
    assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_wb_classic_initiator.sv
// Directed bench for wb_classic_initiator: vector table for single transfers plus hand sequences
// for back-to-back throughput, async reset mid-cycle and the ack-on-timeout race (TIMEOUT=3 instance).
module tb_wb_classic_initiator;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_we = 1'b0;
    logic [31:0] req_adr = '0;
    logic [31:0] req_dat = '0;
    logic [3:0]  req_sel = '0;
    logic        rsp_ready = 1'b0;
    logic [31:0] wbm_dat_i = '0;
    logic        wbm_ack_i = 1'b0;

    logic        req_ready, rsp_valid, rsp_err, wbm_cyc_o, wbm_stb_o, wbm_we_o, busy;
    logic [31:0] rsp_dat, wbm_adr_o, wbm_dat_o;
    logic [3:0]  wbm_sel_o;

    logic        req_valid3 = 1'b0;
    logic        ack3 = 1'b0;
    logic        req_ready3, rsp_valid3, rsp_err3, cyc3, stb3, we3, busy3;
    logic [31:0] rsp_dat3, adr3, dato3;
    logic [3:0]  sel3;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    wb_classic_initiator #(.TIMEOUT(4), .TO_W(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_adr(req_adr), .req_dat(req_dat), .req_sel(req_sel),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_dat(rsp_dat), .rsp_err(rsp_err),
        .wbm_cyc_o(wbm_cyc_o), .wbm_stb_o(wbm_stb_o), .wbm_we_o(wbm_we_o),
        .wbm_sel_o(wbm_sel_o), .wbm_adr_o(wbm_adr_o), .wbm_dat_o(wbm_dat_o),
        .wbm_dat_i(wbm_dat_i), .wbm_ack_i(wbm_ack_i), .busy(busy)
    );

    wb_classic_initiator #(.TIMEOUT(3), .TO_W(8)) dut3 (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid3), .req_ready(req_ready3), .req_we(req_we),
        .req_adr(req_adr), .req_dat(req_dat), .req_sel(req_sel),
        .rsp_valid(rsp_valid3), .rsp_ready(rsp_ready), .rsp_dat(rsp_dat3), .rsp_err(rsp_err3),
        .wbm_cyc_o(cyc3), .wbm_stb_o(stb3), .wbm_we_o(we3),
        .wbm_sel_o(sel3), .wbm_adr_o(adr3), .wbm_dat_o(dato3),
        .wbm_dat_i(wbm_dat_i), .wbm_ack_i(ack3), .busy(busy3)
    );

    typedef struct {
        logic        we;
        logic [31:0] adr;
        logic [31:0] dat;
        logic [3:0]  sel;
        int          wait_n;
        logic [31:0] rdat;
        int          exp_stb;
        logic [31:0] exp_dat;
        logic        exp_err;
        int          hold;
    } vec_t;

    vec_t vecs[6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        int stb_n;
        chk1($sformatf("v%0d req_ready before", idx), req_ready, 1'b1);
        req_valid = 1'b1;
        req_we    = v.we;
        req_adr   = v.adr;
        req_dat   = v.dat;
        req_sel   = v.sel;
        wbm_dat_i = v.rdat;
        @(negedge clk);
        req_valid = 1'b0;
        req_we    = ~v.we;
        req_adr   = ~v.adr;
        req_dat   = ~v.dat;
        req_sel   = ~v.sel;
        chk1($sformatf("v%0d req_ready after accept", idx), req_ready, 1'b0);
        stb_n = 0;
        while (wbm_stb_o && stb_n < 300) begin
            stb_n++;
            chk1($sformatf("v%0d we_o c%0d", idx, stb_n), wbm_we_o, v.we);
            chk($sformatf("v%0d adr_o c%0d", idx, stb_n), wbm_adr_o, v.adr);
            chk($sformatf("v%0d dat_o c%0d", idx, stb_n), wbm_dat_o, v.we ? v.dat : 32'h0);
            chk($sformatf("v%0d sel_o c%0d", idx, stb_n), {28'h0, wbm_sel_o}, {28'h0, v.sel});
            wbm_ack_i = (stb_n == v.wait_n + 1);
            @(negedge clk);
        end
        wbm_ack_i = 1'b0;
        chk($sformatf("v%0d stb cycles", idx), stb_n, v.exp_stb);
        chk1($sformatf("v%0d rsp_valid", idx), rsp_valid, 1'b1);
        chk($sformatf("v%0d rsp_dat", idx), rsp_dat, v.exp_dat);
        chk1($sformatf("v%0d rsp_err", idx), rsp_err, v.exp_err);
        chk1($sformatf("v%0d we_o after", idx), wbm_we_o, 1'b0);
        chk1($sformatf("v%0d busy resp", idx), busy, 1'b1);
        for (int h = 0; h < v.hold; h++) begin
            wbm_ack_i = 1'b1;
            @(negedge clk);
            chk1($sformatf("v%0d hold%0d rsp_valid", idx, h), rsp_valid, 1'b1);
            chk($sformatf("v%0d hold%0d rsp_dat", idx, h), rsp_dat, v.exp_dat);
            chk1($sformatf("v%0d hold%0d rsp_err", idx, h), rsp_err, v.exp_err);
            chk1($sformatf("v%0d hold%0d req_ready", idx, h), req_ready, 1'b0);
            chk1($sformatf("v%0d hold%0d cyc", idx, h), wbm_cyc_o, 1'b0);
        end
        wbm_ack_i = 1'b0;
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        chk1($sformatf("v%0d rsp_valid after hs", idx), rsp_valid, 1'b0);
        chk1($sformatf("v%0d req_ready after hs", idx), req_ready, 1'b1);
        chk1($sformatf("v%0d busy after hs", idx), busy, 1'b0);
        wbm_ack_i = 1'b1;
        @(negedge clk);
        wbm_ack_i = 1'b0;
        chk1($sformatf("v%0d stray ack cyc", idx), wbm_cyc_o, 1'b0);
        chk1($sformatf("v%0d stray ack busy", idx), busy, 1'b0);
        chk1($sformatf("v%0d stray ack rsp_valid", idx), rsp_valid, 1'b0);
    endtask

    initial begin
        int stb_n;
        //          we    adr           dat           sel   wait  rdat          stb exp_dat       err   hold
        vecs[0] = '{1'b1, 32'h3000_0000, 32'h0000_0024, 4'hF, 2,    32'hDEAD_BEEF, 3, 32'h0000_0000, 1'b0, 0};
        vecs[1] = '{1'b0, 32'h3000_0004, 32'h1111_1111, 4'hF, 0,    32'h0000_000C, 1, 32'h0000_000C, 1'b0, 0};
        vecs[2] = '{1'b0, 32'h3000_0008, 32'h0,         4'h3, 1,    32'h1234_5678, 2, 32'h1234_5678, 1'b0, 1};
        vecs[3] = '{1'b0, 32'h3000_000C, 32'h0,         4'hF, 1000, 32'hFFFF_FFFF, 4, 32'h0000_0000, 1'b1, 2};
        vecs[4] = '{1'b1, 32'h3000_0010, 32'hCAFE_0001, 4'h5, 3,    32'h5555_AAAA, 4, 32'h0000_0000, 1'b0, 5};
        vecs[5] = '{1'b0, 32'h3000_0014, 32'h0,         4'hC, 2,    32'h8765_4321, 3, 32'h8765_4321, 1'b0, 5};

        repeat (3) @(negedge clk);
        chk1("reset req_ready", req_ready, 1'b0);
        chk1("reset rsp_valid", rsp_valid, 1'b0);
        chk("reset rsp_dat", rsp_dat, 32'h0);
        chk1("reset rsp_err", rsp_err, 1'b0);
        chk1("reset cyc", wbm_cyc_o, 1'b0);
        chk1("reset stb", wbm_stb_o, 1'b0);
        chk1("reset we", wbm_we_o, 1'b0);
        chk("reset adr", wbm_adr_o, 32'h0);
        chk("reset dat_o", wbm_dat_o, 32'h0);
        chk("reset sel", {28'h0, wbm_sel_o}, 32'h0);
        chk1("reset busy", busy, 1'b0);
        rst_n = 1'b1;
        @(negedge clk);
        chk1("req_ready after release", req_ready, 1'b1);

        for (int i = 0; i < 6; i++) begin
            run_vec(vecs[i], i);
        end

        // Back-to-back zero-wait reads: one accept every 3 clocks.
        req_valid = 1'b1;
        req_we    = 1'b0;
        req_adr   = 32'h3000_0004;
        req_sel   = 4'hF;
        wbm_dat_i = 32'h0000_000C;
        wbm_ack_i = 1'b1;
        rsp_ready = 1'b1;
        for (int i = 1; i <= 9; i++) begin
            @(negedge clk);
            chk1($sformatf("b2b stb n%0d", i), wbm_stb_o, (i % 3) == 1);
            chk1($sformatf("b2b rsp_valid n%0d", i), rsp_valid, (i % 3) == 2);
            if ((i % 3) == 2) begin
                chk($sformatf("b2b rsp_dat n%0d", i), rsp_dat, 32'h0000_000C);
            end
        end
        req_valid = 1'b0;
        wbm_ack_i = 1'b0;
        rsp_ready = 1'b0;
        @(negedge clk);
        chk1("b2b idle", busy, 1'b0);

        // Async reset in the middle of a bus cycle.
        req_valid = 1'b1;
        req_adr   = 32'h3000_0020;
        @(negedge clk);
        req_valid = 1'b0;
        chk1("rst stb before", wbm_stb_o, 1'b1);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk1("rst cyc async", wbm_cyc_o, 1'b0);
        chk1("rst stb async", wbm_stb_o, 1'b0);
        chk1("rst busy async", busy, 1'b0);
        chk1("rst req_ready async", req_ready, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk1("rst req_ready released", req_ready, 1'b1);
        chk1("rst rsp_valid released", rsp_valid, 1'b0);
        chk1("rst busy released", busy, 1'b0);

        // TIMEOUT=3 instance: ack on the 3rd stb cycle coincides with expiry.
        req_valid3 = 1'b1;
        req_we     = 1'b0;
        req_adr    = 32'h3000_0030;
        req_sel    = 4'hF;
        wbm_dat_i  = 32'hA5A5_A5A5;
        @(negedge clk);
        req_valid3 = 1'b0;
        stb_n = 0;
        while (stb3 && stb_n < 300) begin
            stb_n++;
            ack3 = (stb_n == 3);
            @(negedge clk);
        end
        ack3 = 1'b0;
        chk("race stb cycles", stb_n, 3);
        chk1("race rsp_valid", rsp_valid3, 1'b1);
        chk1("race rsp_err", rsp_err3, 1'b0);
        chk("race rsp_dat", rsp_dat3, 32'hA5A5_A5A5);
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        chk1("race rsp_valid after hs", rsp_valid3, 1'b0);
        chk1("race req_ready after hs", req_ready3, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
